// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch/memory/decode signal bundle for instruction_fetch
interface instruction_fetch_if;
    // Instruction memory side
    logic [31:0] o_Addr;
    logic [31:0] i_Instruction;
    // Control-flow redirect from execute
    logic        i_Redirect;
    logic [31:0] i_Redirect_Addr;
    // IF/ID output stream towards decode
    logic        o_Valid;
    logic        i_Ready;
    logic [31:0] o_Instruction;
    logic [31:0] o_PC;
    // Status
    logic        o_Misaligned;
    logic [31:0] o_Fetch_Count;

    // The fetch unit itself
    modport master (
        output o_Addr,
        input  i_Instruction,
        input  i_Redirect,
        input  i_Redirect_Addr,
        output o_Valid,
        input  i_Ready,
        output o_Instruction,
        output o_PC,
        output o_Misaligned,
        output o_Fetch_Count
    );

    // Memory, execute and decode seen as one environment
    modport slave (
        input  o_Addr,
        output i_Instruction,
        output i_Redirect,
        output i_Redirect_Addr,
        input  o_Valid,
        output i_Ready,
        input  o_Instruction,
        input  o_PC,
        input  o_Misaligned,
        input  o_Fetch_Count
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-issue instruction fetch stage with IF/ID register and misalignment trap
module instruction_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          HEIGHT     = 256
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    instruction_fetch_if.master bus
);

    // The memory is word organised; a depth that is not a whole number of
    // words cannot be addressed by this fetch unit. HEIGHT never limits the PC.
    if (HEIGHT < 4 || (HEIGHT % 4) != 0) begin : g_bad_height
        $error("instruction_fetch: HEIGHT must be a positive multiple of 4");
    end

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic        handshake;
    logic        load;
    logic        target_aligned;

    // Decode accepts the held word this edge
    assign handshake      = valid_q & bus.i_Ready;
    // IF/ID register is free to take a new word (empty or being drained)
    assign load           = ~valid_q | bus.i_Ready;
    assign target_aligned = (bus.i_Redirect_Addr[1:0] == 2'b00);

    // State register: RUN after reset, TRAP only via a misaligned redirect
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any redirect picks the state from its target alignment
    always_comb begin
        state_d = state_q;
        if (bus.i_Redirect) begin
            state_d = target_aligned ? ST_RUN : ST_TRAP;
        end
    end

    // Datapath next values: redirect beats load beats stall
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        // A same-cycle redirect still lets the accepted word count
        count_d = count_q + {31'b0, handshake};

        if (bus.i_Redirect) begin
            // Flush the IF/ID register; the target is fetched next edge,
            // or parked in the PC while trapped on a misaligned target.
            pc_d    = bus.i_Redirect_Addr;
            valid_d = 1'b0;
            mis_d   = ~target_aligned;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (load) begin
                        instr_d = bus.i_Instruction;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        // Natural 32-bit wrap from 0xFFFF_FFFC to 0
                        pc_d    = pc_q + 32'd4;
                    end
                end
                ST_TRAP: begin
                    // Frozen until an aligned redirect; i_Ready is irrelevant
                    valid_d = 1'b0;
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers: PC, IF/ID word, trap flag and handshake counter
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pc_q    <= RESET_ADDR;
            instr_q <= 32'h0;
            opc_q   <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            count_q <= count_d;
        end
    end

    // The memory sees the PC directly so its word is ready for the next edge
    assign bus.o_Addr        = pc_q;
    assign bus.o_Valid       = valid_q;
    assign bus.o_Instruction = instr_q;
    assign bus.o_PC          = opc_q;
    assign bus.o_Misaligned  = mis_q;
    assign bus.o_Fetch_Count = count_q;

endmodule
